// File: rtl/gfx_pkg.sv
// Shared graphics constants, sprite geometry and the frame sequencer state encoding.
// Imported by the frame sequencer and by the reusable rectangle fill engine.
package gfx_pkg;

   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COL_W    = 3;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;

   localparam int SPR_W  = 32;
   localparam int SPR_H  = 64;
   localparam int CX_W   = $clog2(SPR_W);
   localparam int CY_W   = $clog2(SPR_H);

   localparam logic [X_W-1:0]   SPR_X     = X_W'(10);
   localparam logic [COL_W-1:0] BG_COLOUR = 3'b000;
   localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(SCREEN_H - SPR_H);

   localparam int               DONE_TIMEOUT = 8191;
   localparam int               TMO_W        = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_ERASE,
      ST_DRAW_REQ,
      ST_DRAW_WAIT,
      ST_FINISH
   } seq_state_t;

   // Keeps the whole sprite on screen.
   function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
      return (y > Y_MAX) ? Y_MAX : y;
   endfunction

endpackage

// File: rtl/rect_fill_engine.sv
// Walks an SPR_W x SPR_H rectangle row-major, one pixel per cycle, from a start pulse.
// Shared by every sprite sequencer that needs to erase its footprint.
module rect_fill_engine
   import gfx_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [X_W-1:0]   x0,
   input  logic [Y_W-1:0]   y0,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             we,
   output logic             last
);

   localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPR_W - 1);
   localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPR_H - 1);

   logic [CX_W-1:0] cx_q, cx_d;
   logic [CY_W-1:0] cy_q, cy_d;
   logic            active_q, active_d;

   // NOTE: every variable gets its hold value first so no path can infer a latch.
   always_comb begin
      cx_d     = cx_q;
      cy_d     = cy_q;
      active_d = active_q;
      if (start) begin
         active_d = 1'b1;
         cx_d     = '0;
         cy_d     = '0;
      end else if (active_q) begin
         cx_d = cx_q + 1'b1;
         if (cx_q == CX_LAST) begin
            cy_d = cy_q + 1'b1;
            if (cy_q == CY_LAST) begin
               active_d = 1'b0;
            end
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cx_q     <= '0;
         cy_q     <= '0;
         active_q <= 1'b0;
      end else begin
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         active_q <= active_d;
      end
   end

   assign x    = x0 + X_W'(cx_q);
   assign y    = y0 + Y_W'(cy_q);
   assign we   = active_q;
   assign last = active_q && (cx_q == CX_LAST) && (cy_q == CY_LAST);

endmodule

// File: rtl/prince_frame_sequencer.sv
// Per-frame draw controller: erase the old prince footprint, trigger the sprite unit,
// and funnel whichever pixel source is active onto one registered VGA write port.
module prince_frame_sequencer
   import gfx_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             frame_tick,
   input  logic [Y_W-1:0]   y_target,
   output logic [Y_W-1:0]   spr_y,
   output logic             spr_plot,
   input  logic             spr_done,
   input  logic [X_W-1:0]   spr_x_in,
   input  logic [Y_W-1:0]   spr_y_in,
   input  logic [COL_W-1:0] spr_col_in,
   input  logic             spr_we_in,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [COL_W-1:0] vga_colour,
   output logic             vga_we,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun,
   output logic             fault
);

   seq_state_t       state_q, state_d;
   logic [Y_W-1:0]   old_y_q, old_y_d;
   logic [Y_W-1:0]   new_y_q, new_y_d;
   logic             old_valid_q, old_valid_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             overrun_q, overrun_d;
   logic             fault_q, fault_d;
   logic [X_W-1:0]   vga_x_q, vga_x_d;
   logic [Y_W-1:0]   vga_y_q, vga_y_d;
   logic [COL_W-1:0] vga_col_q, vga_col_d;
   logic             vga_we_q, vga_we_d;

   logic             erase_start;
   logic [X_W-1:0]   eng_x;
   logic [Y_W-1:0]   eng_y;
   logic             eng_we;
   logic             eng_last;
   logic [Y_W-1:0]   y_clamped;

   rect_fill_engine u_erase (
      .clk    (clk),
      .resetn (resetn),
      .start  (erase_start),
      .x0     (SPR_X),
      .y0     (old_y_q),
      .x      (eng_x),
      .y      (eng_y),
      .we     (eng_we),
      .last   (eng_last)
   );

   assign y_clamped = clamp_y(y_target);

   always_comb begin
      state_d     = state_q;
      old_y_d     = old_y_q;
      new_y_d     = new_y_q;
      old_valid_d = old_valid_q;
      tmo_d       = tmo_q;
      fault_d     = fault_q;
      erase_start = 1'b0;
      spr_plot    = 1'b0;
      frame_done  = 1'b0;
      // Ticks arriving in any non-idle state, FINISH included, are dropped.
      overrun_d   = overrun_q | (frame_tick && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (frame_tick) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            new_y_d = y_clamped;
            if (!old_valid_q || (y_clamped == old_y_q)) begin
               state_d = ST_DRAW_REQ;
            end else begin
               erase_start = 1'b1;
               state_d     = ST_ERASE;
            end
         end
         ST_ERASE: begin
            if (eng_last) state_d = ST_DRAW_REQ;
         end
         ST_DRAW_REQ: begin
            spr_plot = 1'b1;
            tmo_d    = '0;
            state_d  = ST_DRAW_WAIT;
         end
         ST_DRAW_WAIT: begin
            if (spr_done) begin
               state_d = ST_FINISH;
            end else if (tmo_q == TMO_LAST) begin
               fault_d = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_FINISH: begin
            old_y_d     = new_y_q;
            old_valid_d = 1'b1;
            frame_done  = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only one pixel source is live per state; coordinates hold whenever nothing writes.
   always_comb begin
      vga_we_d  = 1'b0;
      vga_x_d   = vga_x_q;
      vga_y_d   = vga_y_q;
      vga_col_d = vga_col_q;
      if (state_q == ST_ERASE && eng_we) begin
         vga_we_d  = 1'b1;
         vga_x_d   = eng_x;
         vga_y_d   = eng_y;
         vga_col_d = BG_COLOUR;
      end else if (state_q == ST_DRAW_WAIT && spr_we_in) begin
         vga_we_d  = 1'b1;
         vga_x_d   = spr_x_in;
         vga_y_d   = spr_y_in;
         vga_col_d = spr_col_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         old_y_q     <= '0;
         new_y_q     <= '0;
         old_valid_q <= 1'b0;
         tmo_q       <= '0;
         overrun_q   <= 1'b0;
         fault_q     <= 1'b0;
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         vga_col_q   <= '0;
         vga_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         old_y_q     <= old_y_d;
         new_y_q     <= new_y_d;
         old_valid_q <= old_valid_d;
         tmo_q       <= tmo_d;
         overrun_q   <= overrun_d;
         fault_q     <= fault_d;
         vga_x_q     <= vga_x_d;
         vga_y_q     <= vga_y_d;
         vga_col_q   <= vga_col_d;
         vga_we_q    <= vga_we_d;
      end
   end

   assign spr_y      = new_y_q;
   assign busy       = (state_q != ST_IDLE);
   assign overrun    = overrun_q;
   assign fault      = fault_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_col_q;
   assign vga_we     = vga_we_q;

endmodule

// File: tb/tb_prince_frame_sequencer.sv
// Directed bench for the prince frame sequencer: inputs change and outputs are sampled on
// the falling edge, with a tiny sprite-unit model answering each plot request.
module tb_prince_frame_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       frame_tick;
   logic [7:0] y_target;
   logic [7:0] spr_y;
   logic       spr_plot;
   logic       spr_done;
   logic [8:0] spr_x_in;
   logic [7:0] spr_y_in;
   logic [2:0] spr_col_in;
   logic       spr_we_in;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_we;
   logic       busy;
   logic       frame_done;
   logic       overrun;
   logic       fault;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Per-frame write statistics gathered on every falling edge.
   int cyc, nw, order_err, last_x, last_y, oy;

   always #5 clk = ~clk;

   prince_frame_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .y_target   (y_target),
      .spr_y      (spr_y),
      .spr_plot   (spr_plot),
      .spr_done   (spr_done),
      .spr_x_in   (spr_x_in),
      .spr_y_in   (spr_y_in),
      .spr_col_in (spr_col_in),
      .spr_we_in  (spr_we_in),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_we     (vga_we),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun),
      .fault      (fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_stats(input int y0);
      cyc = 0; nw = 0; order_err = 0; last_x = -1; last_y = -1; oy = y0;
   endtask

   // One cycle: wait for the falling edge, then log any erase write against row-major order.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (vga_we === 1'b1) begin
         if (int'(vga_x) != 10 + nw % 32 || int'(vga_y) != oy + nw / 32 || vga_colour !== 3'd0)
            order_err++;
         last_x = int'(vga_x);
         last_y = int'(vga_y);
         nw++;
      end
   endtask

   task automatic tick(input logic [7:0] y);
      y_target   = y;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic wait_plot();
      int b = 0;
      while (spr_plot !== 1'b1 && b < 3000) begin
         step();
         b++;
      end
   endtask

   // Sprite unit model: raise done d-1 cycles from now, then expect frame_done and idle.
   task automatic serve(input int d, input string tag);
      for (int i = 1; i < d; i++) step();
      spr_done = 1'b1;
      step();
      spr_done = 1'b0;
      check({tag, "_frame_done"}, frame_done, 1);
      step();
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      resetn = 1'b0; frame_tick = 1'b0; y_target = '0; spr_done = 1'b0;
      spr_x_in = '0; spr_y_in = '0; spr_col_in = '0; spr_we_in = 1'b0;
      clr_stats(0);
      repeat (3) step();
      check("rst_vga_we", vga_we, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_busy", busy, 0);
      check("rst_plot", spr_plot, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_fault", fault, 0);
      check("rst_spr_y", spr_y, 0);
      resetn = 1'b1;
      step();

      // 1: first frame, nothing to erase; sprite pixels pass through the output register.
      clr_stats(0);
      tick(8'd50);
      wait_plot();
      check("t1_plot_latency", cyc, 2);
      check("t1_no_erase", nw, 0);
      check("t1_spr_y", spr_y, 50);
      step();
      spr_we_in = 1'b1; spr_x_in = 9'd123; spr_y_in = 8'd45; spr_col_in = 3'd5;
      step();
      check("t1_pass_we", vga_we, 1);
      check("t1_pass_x", vga_x, 123);
      check("t1_pass_y", vga_y, 45);
      check("t1_pass_col", vga_colour, 5);
      spr_we_in = 1'b0; spr_x_in = 9'd7; spr_y_in = 8'd9; spr_col_in = 3'd2;
      step();
      check("t1_hold_we", vga_we, 0);
      check("t1_hold_x", vga_x, 123);
      check("t1_hold_col", vga_colour, 5);
      serve(4100 - 3, "t1");
      check("t1_fault", fault, 0);

      // 2: move to 80, erase the 32x64 block at rows 50..113.
      clr_stats(50);
      tick(8'd80);
      wait_plot();
      check("t2_plot_latency", cyc, 2050);
      check("t2_erase_writes", nw, 2048);
      check("t2_erase_order", order_err, 0);
      check("t2_last_x", last_x, 41);
      check("t2_last_y", last_y, 113);
      check("t2_spr_y", spr_y, 80);
      serve(20, "t2");

      // 3: same row again, erase skipped.
      clr_stats(80);
      tick(8'd80);
      wait_plot();
      check("t3_plot_latency", cyc, 2);
      check("t3_no_erase", nw, 0);
      serve(5, "t3");

      // 4: clamp 200 to 176; erase uses old row 80, then the next erase covers 176..239.
      clr_stats(80);
      tick(8'd200);
      wait_plot();
      check("t4_spr_y", spr_y, 176);
      check("t4_erase_writes", nw, 2048);
      check("t4_erase_order", order_err, 0);
      check("t4_last_y", last_y, 143);
      serve(5, "t4");
      clr_stats(176);
      tick(8'd10);
      wait_plot();
      check("t4b_erase_writes", nw, 2048);
      check("t4b_erase_order", order_err, 0);
      check("t4b_last_y", last_y, 239);
      check("t4b_spr_y", spr_y, 10);
      serve(5, "t4b");

      // 5: sprite unit never answers; timeout after 8191 wait cycles.
      clr_stats(10);
      tick(8'd10);
      wait_plot();
      check("t5_plot_latency", cyc, 2);
      begin
         int n = 0;
         while (fault !== 1'b1 && n < 9000) begin
            step();
            n++;
         end
         check("t5_timeout_cycles", n, 8192);
      end
      check("t5_frame_done", frame_done, 1);
      step();
      check("t5_idle", busy, 0);
      clr_stats(10);
      tick(8'd10);
      wait_plot();
      check("t5_recover_latency", cyc, 2);
      serve(5, "t5r");
      check("t5_fault_sticky", fault, 1);

      // 6: a tick mid-erase is dropped and flagged; the frame continues untouched.
      clr_stats(10);
      tick(8'd100);
      repeat (100) step();
      check("t6_overrun_before", overrun, 0);
      tick(8'd33);
      check("t6_overrun_set", overrun, 1);
      wait_plot();
      check("t6_plot_latency", cyc, 2050);
      check("t6_erase_writes", nw, 2048);
      check("t6_erase_order", order_err, 0);
      check("t6_spr_y", spr_y, 100);
      serve(5, "t6");

      // 6b: reset during erase aborts and forgets the previous footprint.
      clr_stats(100);
      tick(8'd50);
      repeat (50) step();
      check("t6b_erasing", vga_we, 1);
      resetn = 1'b0;
      step();
      check("t6b_rst_vga_we", vga_we, 0);
      check("t6b_rst_busy", busy, 0);
      check("t6b_rst_overrun", overrun, 0);
      check("t6b_rst_fault", fault, 0);
      resetn = 1'b1;
      clr_stats(0);
      tick(8'd50);
      wait_plot();
      check("t6b_plot_latency", cyc, 2);
      check("t6b_no_erase", nw, 0);
      serve(5, "t6b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
